// File: rtl/wb_arbiter_pkg.sv
// Shared core definitions for the writeback path: the architectural data
// width, the register index width and the layout of one writeback entry.
package core_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    // One pending register-file write: destination index plus result.
    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_entry_t;

endpackage

// File: rtl/wb_arbiter_if.sv
// Bundle of the writeback arbiter's bus signals: ALU result, LSU handshake,
// register-file write port, FIFO occupancy and the decode hazard query.
// The slave modport is the arbiter's view; master is the surrounding core.
interface wb_arbiter_if #(
    parameter int DEPTH = 4,
    parameter int XLEN  = core_pkg::XLEN,
    parameter int AW    = core_pkg::REG_AW
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic            alu_we;
    logic [AW-1:0]   alu_rd;
    logic [XLEN-1:0] alu_data;

    logic            lsu_valid;
    logic            lsu_ready;
    logic [AW-1:0]   lsu_rd;
    logic [XLEN-1:0] lsu_data;

    logic            rf_we;
    logic [AW-1:0]   rf_rd;
    logic [XLEN-1:0] rf_data;

    logic [CW-1:0]   fifo_count;

    logic [AW-1:0]   chk_rd;
    logic            chk_hit;

    modport slave (
        input  alu_we, alu_rd, alu_data,
        input  lsu_valid, lsu_rd, lsu_data,
        output lsu_ready,
        output rf_we, rf_rd, rf_data,
        output fifo_count,
        input  chk_rd,
        output chk_hit
    );

    modport master (
        output alu_we, alu_rd, alu_data,
        output lsu_valid, lsu_rd, lsu_data,
        input  lsu_ready,
        input  rf_we, rf_rd, rf_data,
        input  fifo_count,
        output chk_rd,
        input  chk_hit
    );

endinterface

// File: rtl/wb_arbiter_fifo.sv
// Synchronous FIFO buffering LSU writeback results. Pointers carry one extra
// wrap bit so full and empty are distinguishable. Every entry's destination
// index is visible so the hazard query can search all queued writes.
module wb_fifo #(
    parameter int DEPTH = 4,
    parameter int XLEN  = core_pkg::XLEN,
    parameter int AW    = core_pkg::REG_AW
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [AW-1:0]            pushRd,
    input  logic [XLEN-1:0]          pushData,
    input  logic                     pop,
    output logic [AW-1:0]            popRd,
    output logic [XLEN-1:0]          popData,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    input  logic [AW-1:0]            chkRd,
    output logic                     chkHit
);
    import core_pkg::*;

    localparam int PW = $clog2(DEPTH);

    logic [AW-1:0]   rdMem   [DEPTH];
    logic [XLEN-1:0] dataMem [DEPTH];

    logic [PW:0] wrPtrReg;
    logic [PW:0] rdPtrReg;
    logic        doPush;
    logic        doPop;

    // Guard against overflow/underflow even if the caller misbehaves.
    assign doPush = push && !full;
    assign doPop  = pop && !empty;

    assign count = wrPtrReg - rdPtrReg;
    assign empty = (wrPtrReg == rdPtrReg);
    assign full  = (wrPtrReg[PW] != rdPtrReg[PW]) &&
                   (wrPtrReg[PW-1:0] == rdPtrReg[PW-1:0]);

    assign popRd   = rdMem[rdPtrReg[PW-1:0]];
    assign popData = dataMem[rdPtrReg[PW-1:0]];

    // Pointer advance; reset flushes the queue by collapsing both pointers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtrReg <= '0;
            rdPtrReg <= '0;
        end else begin
            if (doPush) wrPtrReg <= wrPtrReg + 1'b1;
            if (doPop)  rdPtrReg <= rdPtrReg + 1'b1;
        end
    end

    // Entry storage: no reset needed, validity comes from the pointers.
    always_ff @(posedge clk) begin
        if (doPush) begin
            rdMem[wrPtrReg[PW-1:0]]   <= pushRd;
            dataMem[wrPtrReg[PW-1:0]] <= pushData;
        end
    end

    // An entry is live when its distance from the read pointer is below
    // the occupancy; only live entries may report a hazard.
    logic [DEPTH-1:0] entryHit;
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_hit
            logic [PW-1:0] offset;
            assign offset       = PW'(gi) - rdPtrReg[PW-1:0];
            assign entryHit[gi] = ({1'b0, offset} < count) && (rdMem[gi] == chkRd);
        end
    endgenerate

    assign chkHit = |entryHit;

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter feeding the register file's single write port.
// The ALU path has fixed priority and is never stalled; LSU results are
// queued in wb_fifo and drained whenever the ALU is idle. Writes to r0 are
// dropped at the input. Optional macro WB_LSU_BYPASS_EN lets an LSU result
// skip the empty FIFO and reach the register file in one cycle.
module wb_arbiter
    import core_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int XLEN  = core_pkg::XLEN,
    parameter int AW    = core_pkg::REG_AW
) (
    input  logic          clk,
    input  logic          rst,
    wb_arbiter_if.slave   bus
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic            aluWrite;
    logic            lsuReady;
    logic            lsuFire;
    logic            lsuLive;
    logic            bypassTake;
    logic            fifoPush;
    logic            fifoPop;
    logic            fifoFull;
    logic            fifoEmpty;
    logic            fifoHit;
    logic [CW-1:0]   fifoCount;
    logic [AW-1:0]   headRd;
    logic [XLEN-1:0] headData;

    logic            rfWeReg;
    logic [AW-1:0]   rfRdReg;
    logic [XLEN-1:0] rfDataReg;

    // r0 is hardwired zero, so writes to it are treated as no write.
    assign aluWrite = bus.alu_we && (bus.alu_rd != '0);

    // Ready depends on registered occupancy only, never on lsu_valid.
    assign lsuReady = !fifoFull;
    assign lsuFire  = bus.lsu_valid && lsuReady;
    assign lsuLive  = lsuFire && (bus.lsu_rd != '0);

`ifdef WB_LSU_BYPASS_EN
    // Nothing queued and no ALU write: the LSU result can go straight out.
    assign bypassTake = lsuLive && fifoEmpty && !aluWrite;
`else
    assign bypassTake = 1'b0;
`endif

    assign fifoPush = lsuLive && !bypassTake;
    assign fifoPop  = !aluWrite && !fifoEmpty;

    wb_fifo #(
        .DEPTH (DEPTH),
        .XLEN  (XLEN),
        .AW    (AW)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (fifoPush),
        .pushRd   (bus.lsu_rd),
        .pushData (bus.lsu_data),
        .pop      (fifoPop),
        .popRd    (headRd),
        .popData  (headData),
        .full     (fifoFull),
        .empty    (fifoEmpty),
        .count    (fifoCount),
        .chkRd    (bus.chk_rd),
        .chkHit   (fifoHit)
    );

    // Output stage: ALU first, then FIFO head, then bypassed LSU; when idle
    // only the write enable drops and index/data hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            rfWeReg   <= 1'b0;
            rfRdReg   <= '0;
            rfDataReg <= '0;
        end else if (aluWrite) begin
            rfWeReg   <= 1'b1;
            rfRdReg   <= bus.alu_rd;
            rfDataReg <= bus.alu_data;
        end else if (fifoPop) begin
            rfWeReg   <= 1'b1;
            rfRdReg   <= headRd;
            rfDataReg <= headData;
        end else if (bypassTake) begin
            rfWeReg   <= 1'b1;
            rfRdReg   <= bus.lsu_rd;
            rfDataReg <= bus.lsu_data;
        end else begin
            rfWeReg   <= 1'b0;
        end
    end

    assign bus.lsu_ready  = lsuReady;
    assign bus.rf_we      = rfWeReg;
    assign bus.rf_rd      = rfRdReg;
    assign bus.rf_data    = rfDataReg;
    assign bus.fifo_count = fifoCount;

    // A write is pending if it is queued or sitting in the output stage.
    assign bus.chk_hit = (bus.chk_rd != '0) &&
                         (fifoHit || (rfWeReg && (rfRdReg == bus.chk_rd)));

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Writeback arbiter directly upstream of the 32x32 register file; drives its single write port (writeEnable/writeReg/writeData).
- Merges two result sources:
  - the single-cycle ALU path, which never stalls and has fixed priority;
  - the long-latency load/muldiv path (LSU), which uses a valid/ready handshake and is buffered in a small FIFO.
- Exposes a pending-destination query so decode can stall on hazards against queued writes.

Parameters:
- DEPTH, 4: LSU FIFO entries; power of two, >=2.
- XLEN, 32: data width.
- AW, 5: register index width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- alu_we  in  1  ALU result valid this cycle; always accepted.
- alu_rd  in  AW  ALU destination register.
- alu_data  in  XLEN  ALU result.
- lsu_valid  in  1  LSU result offered.
- lsu_ready  out  1  arbiter can accept an LSU result.
- lsu_rd  in  AW  LSU destination register.
- lsu_data  in  XLEN  LSU result.
- rf_we  out  1  to register file writeEnable.
- rf_rd  out  AW  to register file writeReg.
- rf_data  out  XLEN  to register file writeData.
- fifo_count  out  $clog2(DEPTH)+1  queued LSU entries.
- chk_rd  in  AW  decode query register index.
- chk_hit  out  1  chk_rd has a write pending in the FIFO or in the rf_* output stage.

Behaviour:
- Reset: rst is synchronous, active-high; clk is the clock.
  - On reset: rf_we=0, rf_rd=0, rf_data=0, FIFO flushed, fifo_count=0.
  - lsu_ready=1 in the first cycle after reset.
  - Reset mid-operation discards all queued and in-flight writes. No rf_we pulse follows.
- LSU handshake:
  - lsu_ready = (fifo_count < DEPTH). It is a function of registered state only and never depends on lsu_valid.
  - A transfer occurs on a clock edge where lsu_valid && lsu_ready.
  - Upstream holds rd/data stable while valid && !ready.
- rd==0 discard: an accepted transfer with lsu_rd==0 completes the handshake but is not enqueued. An ALU write with alu_rd==0 is treated as alu_we=0.
- Output register update, at each clock edge in priority order:
  1. alu_we && alu_rd!=0: rf_we<=1, rf_rd<=alu_rd, rf_data<=alu_data. The FIFO head is not popped.
  2. Else if the FIFO is non-empty: pop the head into rf_*, with rf_we<=1.
  3. Else: rf_we<=0. rf_rd and rf_data hold their previous values.
- Latency:
  - ALU: 1 cycle to rf_we.
  - LSU via FIFO: at least 2 cycles from acceptance to rf_we (edge N enqueue, edge N+1 output).
  - The LSU is starved for as long as alu_we is held.
- Push and pop in the same cycle: allowed whenever not full; fifo_count is unchanged. When the FIFO is full, ready is already 0, so no push can occur even if a pop happens.
- FIFO pointers wrap modulo DEPTH. Each pointer carries an extra bit to distinguish full from empty.
- chk_hit (combinational):
  - chk_rd!=0, and
  - either any valid FIFO entry has rd==chk_rd, or (rf_we && rf_rd==chk_rd).
- Ordering contract: the ALU may overtake queued LSU writes. Decode must stall any instruction whose rd or rs hits chk_hit, so WAW and RAW ordering is the issuer's responsibility. The block does not reorder or cancel entries.

Optional Feature:
- Macro: WB_LSU_BYPASS_EN.
- When defined: if the FIFO is empty, alu_we is inactive and an LSU transfer with rd!=0 occurs, the transfer is written straight into rf_* at that same edge. It is not enqueued and fifo_count stays 0, giving 1-cycle LSU latency.
- When undefined: every LSU result passes through the FIFO, giving at least 2-cycle latency.
- Either way, lsu_ready is identical.

Decomposition:
- Shared package core_pkg holds:
  - XLEN and REG_AW constants;
  - wb_entry_t {rd[AW], data[XLEN]}.
- One sub-module: wb_fifo, a synchronous FIFO parameterised by DEPTH with push/pop/full/empty/count and per-entry rd visibility for chk_hit. The arbitration and output register stay in wb_arbiter.

Test Plan:
- ALU only: alu_we=1, rd=5, data=0xDEADBEEF at edge N -> rf_we=1, rf_rd=5, rf_data=0xDEADBEEF after edge N. With alu_rd=0 -> rf_we=0.
- LSU only, bypass off: one transfer rd=7, data=0x1234 -> fifo_count=1 after edge N; rf_we=1, rf_rd=7 after edge N+1; fifo_count=0.
- Contention: alu_we held for 6 cycles while 5 LSU transfers are offered (DEPTH=4):
  - lsu_ready drops after 4 accepts; fifo_count=4;
  - after alu_we falls, the 4 entries drain in FIFO order over 4 consecutive cycles;
  - the 5th transfer is then accepted.
- Hazard query: enqueue rd=9, chk_rd=9 -> chk_hit=1 until the cycle after its rf_we pulse. chk_rd=0 -> chk_hit=0 always.
- Reset mid-operation: FIFO holding 3 entries, assert rst for 1 cycle -> rf_we=0, fifo_count=0, lsu_ready=1, and no later write of the flushed entries.
- WB_LSU_BYPASS_EN defined: FIFO empty, no ALU write, LSU rd=3 data=0xA5 -> rf_we=1, rf_rd=3 after the same edge; fifo_count stays 0.
